gbuff_out_reader: RTL and testbench

Result drain engine for the matrix-multiply datapath. After the controller finishes a job and raises its `out_valid`, this block reads the filled output global buffer word by word through its read index/data port. It streams the words to a downstream consumer over a valid/ready interface with full backpressure support and marks the final word. It is the reader for the words the controller writes into the output buffer.

---
 rtl/gbuff_out_reader.sv | 128 ++++++++++++
 tb/tb_gbuff_out_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gbuff_out_reader.sv
// Drains the filled output global buffer word by word and streams it over a
// valid/ready interface with full backpressure, marking the final word.
module gbuff_out_reader #(
    parameter int WORD_SIZE = 32,
    parameter int ROW_SIZE  = 5,
    parameter int DEPTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_SIZE:0]     count,
    output logic [ROW_SIZE-1:0]   buf_idx,
    input  logic [WORD_SIZE-1:0]  buf_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_SIZE-1:0]  m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ROW_SIZE:0] DEPTH_C = (ROW_SIZE + 1)'(DEPTH);
    localparam logic [ROW_SIZE:0] ONE_C   = (ROW_SIZE + 1)'(1);
    localparam logic [ROW_SIZE:0] ZERO_C  = (ROW_SIZE + 1)'(0);

    state_t                 state_r, state_s;
    logic [ROW_SIZE:0]      rd_ptr_r, rd_ptr_s;
    logic [ROW_SIZE:0]      remaining_r, remaining_s;
    logic                   m_valid_r, m_valid_s;
    logic                   m_last_r, m_last_s;
    logic [WORD_SIZE-1:0]   m_data_r, m_data_s;
    logic [ROW_SIZE-1:0]    buf_idx_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   fetch_s;
    logic                   xfer_s;

    // Next-state, fetch and handshake decode.
    always_comb begin
        state_s     = state_r;
        rd_ptr_s    = rd_ptr_r;
        remaining_s = remaining_r;
        m_valid_s   = m_valid_r;
        m_last_s    = m_last_r;
        m_data_s    = m_data_r;
        fetch_s     = 1'b0;
        xfer_s      = m_valid_r && m_ready;
        case (state_r)
            IDLE: begin
                // A zero-length job passes one empty STREAM cycle before DONE.
                if (start) begin
                    state_s     = STREAM;
                    rd_ptr_s    = ZERO_C;
                    remaining_s = (count > DEPTH_C) ? DEPTH_C : count;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                fetch_s = (remaining_r != ZERO_C) && (!m_valid_r || m_ready);
                if (fetch_s) begin
                    m_data_s    = buf_data;
                    m_valid_s   = 1'b1;
                    m_last_s    = (remaining_r == ONE_C);
                    rd_ptr_s    = rd_ptr_r + ONE_C;
                    remaining_s = remaining_r - ONE_C;
                end else if (xfer_s) begin
                    m_valid_s = 1'b0;
                    m_last_s  = 1'b0;
                end else begin
                    m_valid_s = m_valid_r;
                end
                if (xfer_s && m_last_r) begin
                    state_s = DONE;
                end else if ((remaining_r == ZERO_C) && !m_valid_r) begin
                    state_s = DONE;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; status outputs are derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rd_ptr_r    <= ZERO_C;
            remaining_r <= ZERO_C;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            m_data_r    <= {WORD_SIZE{1'b0}};
            buf_idx_r   <= {ROW_SIZE{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rd_ptr_r    <= rd_ptr_s;
            remaining_r <= remaining_s;
            m_valid_r   <= m_valid_s;
            m_last_r    <= m_last_s;
            m_data_r    <= m_data_s;
            buf_idx_r   <= (state_s == STREAM) ? rd_ptr_s[ROW_SIZE-1:0] : {ROW_SIZE{1'b0}};
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    assign buf_idx = buf_idx_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;
    assign m_data  = m_data_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_gbuff_out_reader.sv
// Directed bench for gbuff_out_reader: a combinational buffer model feeds the
// DUT and each scenario task compares collected beats against hand values.
module tb_gbuff_out_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  count;
    logic [4:0]  buf_idx;
    logic [31:0] buf_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];

    int vectors;
    int miscompares;

    logic [31:0] beats [$];
    logic        lasts [$];
    logic [4:0]  idxs  [$];
    int done_at, done_cnt, cycles, stall_err, first_at, valid_cnt;
    bit timeout;

    gbuff_out_reader #(.WORD_SIZE(32), .ROW_SIZE(5), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count),
        .buf_idx(buf_idx), .buf_data(buf_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    assign buf_data = mem[buf_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job; cycle i is the cycle following edge E_i (E0 samples start).
    task automatic run_job(input logic [5:0] cnt, input logic [3:0] pat,
                           input int inject_at, input int abort_beats, input int max_cyc);
        logic        pstall;
        logic [31:0] pd;
        logic        pl;
        logic [4:0]  pi;
        beats.delete(); lasts.delete(); idxs.delete();
        done_at = -1; first_at = -1; done_cnt = 0; cycles = -1;
        stall_err = 0; valid_cnt = 0; timeout = 1'b0;
        pstall = 1'b0; pd = 32'd0; pl = 1'b0; pi = 5'd0;
        @(negedge clk);
        start = 1'b1;
        count = cnt;
        for (int i = 0; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            m_ready = pat[i % 4];
            if (i == inject_at) begin
                start = 1'b1;
                count = 6'd4;
            end
            @(negedge clk);
            if (pstall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl || buf_idx !== pi))
                stall_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (m_valid === 1'b1) valid_cnt++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (first_at < 0) first_at = i;
                beats.push_back(m_data);
                lasts.push_back(m_last);
                idxs.push_back(buf_idx);
            end
            pstall = (m_valid === 1'b1) && (m_ready === 1'b0);
            pd = m_data; pl = m_last; pi = buf_idx;
            if (abort_beats > 0 && beats.size() == abort_beats) begin
                rst_n = 1'b0;
                #1;
                return;
            end
            if (busy === 1'b0) begin
                cycles = i;
                return;
            end
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset();
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        vectors++; if (m_data !== 32'd0) begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (buf_idx !== 5'd0) begin miscompares++; $display("FAIL reset_buf_idx: got %0d want 0", buf_idx); end
    endtask

    task automatic test_full_drain();
        int last_cnt;
        run_job(6'd32, 4'b1111, -1, 0, 60);
        vectors++; if (timeout) begin miscompares++; $display("FAIL full_timeout: got 1 want 0"); end
        vectors++; if (beats.size() != 32) begin miscompares++; $display("FAIL full_beats: got %0d want 32", beats.size()); end
        last_cnt = 0;
        for (int k = 0; k < beats.size(); k++) begin
            vectors++;
            if (beats[k] !== 32'h1000_0000 + k) begin miscompares++; $display("FAIL full_data[%0d]: got %h want %h", k, beats[k], 32'h1000_0000 + k); end
            vectors++;
            if (idxs[k] !== 5'((k + 1) % 32)) begin miscompares++; $display("FAIL full_idx[%0d]: got %0d want %0d", k, idxs[k], (k + 1) % 32); end
            if (lasts[k] === 1'b1) last_cnt++;
        end
        vectors++; if (last_cnt != 1 || lasts.size() != 32 || lasts[31] !== 1'b1) begin miscompares++; $display("FAIL full_last: got count %0d want 1 on beat 31", last_cnt); end
        vectors++; if (first_at != 1) begin miscompares++; $display("FAIL full_first_beat: got cycle %0d want 1", first_at); end
        vectors++; if (done_at != 33 || done_cnt != 1) begin miscompares++; $display("FAIL full_done: got cycle %0d x%0d want 33 x1", done_at, done_cnt); end
        vectors++; if (cycles != 34) begin miscompares++; $display("FAIL full_busy_low: got %0d want 34", cycles); end
    endtask

    task automatic test_backpressure();
        run_job(6'd8, 4'b1001, -1, 0, 60);
        vectors++; if (beats.size() != 8) begin miscompares++; $display("FAIL bp_beats: got %0d want 8", beats.size()); end
        for (int k = 0; k < beats.size(); k++) begin
            vectors++;
            if (beats[k] !== 32'h1000_0000 + k) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", k, beats[k], 32'h1000_0000 + k); end
        end
        vectors++; if (stall_err != 0) begin miscompares++; $display("FAIL bp_stall_hold: got %0d unstable stalls want 0", stall_err); end
        vectors++; if (lasts.size() != 8 || lasts[7] !== 1'b1 || lasts[6] !== 1'b0) begin miscompares++; $display("FAIL bp_last: m_last not only on beat 7"); end
        vectors++; if (done_at != 17 || done_cnt != 1) begin miscompares++; $display("FAIL bp_done: got cycle %0d x%0d want 17 x1", done_at, done_cnt); end
        vectors++; if (cycles != 18) begin miscompares++; $display("FAIL bp_busy_low: got %0d want 18", cycles); end
    endtask

    task automatic test_zero_length();
        run_job(6'd0, 4'b1111, -1, 0, 20);
        vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL zero_valid: got %0d valid cycles want 0", valid_cnt); end
        vectors++; if (done_at != 1 || done_cnt != 1) begin miscompares++; $display("FAIL zero_done: got cycle %0d x%0d want 1 x1", done_at, done_cnt); end
        vectors++; if (cycles != 2) begin miscompares++; $display("FAIL zero_busy_low: got %0d want 2", cycles); end
    endtask

    task automatic test_clamp();
        run_job(6'b101000, 4'b1111, -1, 0, 60);
        vectors++; if (beats.size() != 32) begin miscompares++; $display("FAIL clamp_beats: got %0d want 32", beats.size()); end
        vectors++; if (beats.size() != 32 || beats[31] !== 32'h1000_001F || lasts[31] !== 1'b1) begin miscompares++; $display("FAIL clamp_last: final beat not 1000001f with m_last"); end
        vectors++; if (cycles != 34) begin miscompares++; $display("FAIL clamp_busy_low: got %0d want 34", cycles); end
    endtask

    task automatic test_start_during_job();
        run_job(6'd8, 4'b1111, 3, 0, 40);
        vectors++; if (beats.size() != 8) begin miscompares++; $display("FAIL busy_start_beats: got %0d want 8", beats.size()); end
        vectors++; if (done_cnt != 1 || cycles != 10) begin miscompares++; $display("FAIL busy_start_done: got x%0d busy low %0d want x1 10", done_cnt, cycles); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_queued: got busy %b want 0", busy); end
        end
    endtask

    task automatic test_reset_mid_stream();
        run_job(6'd16, 4'b1111, -1, 3, 40);
        test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: got done %b busy %b want 0 0", done, busy); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_job(6'd2, 4'b1111, -1, 0, 20);
        vectors++; if (beats.size() != 2) begin miscompares++; $display("FAIL rst_mid_beats: got %0d want 2", beats.size()); end
        vectors++; if (beats.size() != 2 || beats[0] !== 32'h1000_0000 || beats[1] !== 32'h1000_0001 || lasts[1] !== 1'b1) begin miscompares++; $display("FAIL rst_mid_data: wrong beats after restart"); end
        vectors++; if (done_at != 3 || done_cnt != 1 || cycles != 4) begin miscompares++; $display("FAIL rst_mid_done: got cycle %0d x%0d low %0d want 3 x1 4", done_at, done_cnt, cycles); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        rst_n = 1'b0; start = 1'b0; count = 6'd0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_full_drain();
        test_backpressure();
        test_zero_length();
        test_clamp();
        test_start_during_job();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
